ropuf_challenge_sequencer: RTL and testbench
============================================

// Module: ropuf_challenge_sequencer
// PURPOSE
//  Sequences the RO-PUF race datapath through every RO-pair challenge.
//  For each SEL value it clears the edge counters, enables the oscillators and waits for the first
//   counter carry-out (COUT1/COUT2), then records one response bit.
//  Assembles an NUM_CHAL-bit response word and reports tie/timeout errors.
//  Sits between the system controller (START/RESP) and the PUF core (EN/SEL/RESET/COUT1/COUT2).
// PARAMETERS
//  SEL_W     2     width of challenge select driven to the PUF core
//  NUM_CHAL  4     challenges per run, SEL = 0..NUM_CHAL-1 (NUM_CHAL <= 2**SEL_W)
//  CLR_CYC   4     cycles RO_RST held per challenge (must be >= 3, flushes synchronizers)
//  TIMEOUT   1024  max RACE cycles per challenge before forced result
//  TMR_W     11    timer width, must hold TIMEOUT
// PORTS
//  CLK          in   1         system clock, all state on rising edge
//  RESET_N      in   1         asynchronous active-low reset
//  START        in   1         request a run; honoured only in IDLE
//  BUSY         out  1         high from cycle after START accepted until DONE cycle inclusive
//  SEL          out  SEL_W     current challenge to PUF core
//  RO_EN        out  1         ring-oscillator enable (PUF EN)
//  RO_RST       out  1         active-high counter clear (PUF RESET)
//  COUT1        in   1         carry-out of counter 1, asynchronous to CLK
//  COUT2        in   1         carry-out of counter 2, asynchronous to CLK
//  RESP         out  NUM_CHAL  response word, RESP[i] = result of challenge SEL=i
//  RESP_VALID   out  1         RESP complete; held until next accepted START
//  DONE         out  1         one-cycle pulse when run completes
//  TIE_ERR      out  1         sticky: some challenge saw both carries in same cycle
//  TIMEOUT_ERR  out  1         sticky: some challenge hit TIMEOUT
// BEHAVIOUR
//  Reset: state IDLE, SEL=0, RO_EN=0, RO_RST=1, RESP=0, RESP_VALID=0, DONE=0, BUSY=0, both
//   errors=0, index/timer=0, synchronizers=0. Applies immediately, including mid-run (oscillators
//   stop asynchronously); no partial result retained.
//  COUT1/COUT2 each pass a 2-flop synchronizer (c1s/c2s); only synchronized values are used.
//  FSM: IDLE -> CLEAR -> RACE -> CAPTURE -> (CLEAR | FINISH) -> IDLE.
//  IDLE: RO_EN=0, RO_RST=1. START=1 at edge k: idx=0, SEL=0, RESP=0, RESP_VALID=0, errors cleared,
//   go CLEAR at k+1.
//  CLEAR: RO_RST=1, RO_EN=0, SEL=idx, CLR_CYC cycles exactly, then RACE.
//  RACE: RO_RST=0, RO_EN=1, timer counts from 0 each cycle. Evaluate per cycle:
//   c1s&~c2s -> bit=1; c2s&~c1s -> bit=0; c1s&c2s -> bit=0, TIE_ERR<=1;
//   neither and timer==TIMEOUT-1 -> bit=0, TIMEOUT_ERR<=1 (RO_EN high exactly TIMEOUT cycles).
//   Any of these -> CAPTURE next cycle.
//  CAPTURE (1 cycle): RO_EN=0, RO_RST=0, RESP[idx]<=bit. idx==NUM_CHAL-1 -> FINISH,
//   else idx++ -> CLEAR.
//  FINISH (1 cycle): DONE=1, RESP_VALID=1, BUSY=1; next cycle IDLE, BUSY=0.
//  START outside IDLE ignored (not queued). START held high in IDLE re-launches every entry.
//  SEL changes only on CLEAR entry; never changes while RO_EN=1.
//  RO_EN and RO_RST are registered outputs, never both 1.
//  Latency per challenge = CLR_CYC + race cycles + 1; carry -> RESP bit <= 4 CLK (2 sync + decide
//   + capture).
// TESTING
//  1 Reset: RESET_N=0 -> SEL=0, RO_EN=0, RO_RST=1, RESP=0, RESP_VALID=DONE=BUSY=0, errors=0.
//  2 Normal run, defaults: model COUT1 first (20 cyc after RO_EN) for SEL 0,2, COUT2 first for
//    1,3 -> RESP=4'b0101, one DONE pulse, RESP_VALID=1, TIE_ERR=TIMEOUT_ERR=0, each
//    RO_RST pulse = 4 cyc.
//  3 Tie: COUT1 and COUT2 rise same edge on SEL=1 -> RESP[1]=0, TIE_ERR=1, run still completes.
//  4 Timeout (TIMEOUT=64): no carry on SEL=3 -> RO_EN high exactly 64 cyc, RESP[3]=0,
//    TIMEOUT_ERR=1.
//  5 START pulsed during RACE -> ignored, single DONE; new START in IDLE clears RESP_VALID and
//    errors next cycle.
//  6 RESET_N low during RACE of SEL=2 -> RO_EN=0 and RO_RST=1 without clock; next START begins
//    at SEL=0.

Source files
------------

// File: rtl/ropuf_challenge_sequencer.sv
// RO-PUF challenge sequencer: walks SEL through every challenge, races the two
// ring-oscillator counters per challenge and assembles the response word.
module ropuf_challenge_sequencer #(
    parameter int SEL_W    = 2,
    parameter int NUM_CHAL = 4,
    parameter int CLR_CYC  = 4,
    parameter int TIMEOUT  = 1024,
    parameter int TMR_W    = 11
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                START,
    output logic                BUSY,
    output logic [SEL_W-1:0]    SEL,
    output logic                RO_EN,
    output logic                RO_RST,
    input  logic                COUT1,
    input  logic                COUT2,
    output logic [NUM_CHAL-1:0] RESP,
    output logic                RESP_VALID,
    output logic                DONE,
    output logic                TIE_ERR,
    output logic                TIMEOUT_ERR
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RACE,
        CAPTURE,
        FINISH
    } state_t;

    localparam logic [TMR_W-1:0] CLR_LAST  = TMR_W'(CLR_CYC - 1);
    localparam logic [TMR_W-1:0] RACE_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [SEL_W-1:0] IDX_LAST  = SEL_W'(NUM_CHAL - 1);

    state_t           state;
    logic [SEL_W-1:0] idx;
    logic [TMR_W-1:0] timer;
    logic             race_bit;
    logic             c1_meta;
    logic             c1s;
    logic             c2_meta;
    logic             c2s;

    // The carries come from the free-running oscillator domain; only the
    // second synchronizer stage is ever allowed to influence a decision.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            c1_meta     <= 1'b0;
            c1s         <= 1'b0;
            c2_meta     <= 1'b0;
            c2s         <= 1'b0;
            state       <= IDLE;
            idx         <= '0;
            timer       <= '0;
            race_bit    <= 1'b0;
            SEL         <= '0;
            RO_EN       <= 1'b0;
            RO_RST      <= 1'b1;
            RESP        <= '0;
            RESP_VALID  <= 1'b0;
            DONE        <= 1'b0;
            BUSY        <= 1'b0;
            TIE_ERR     <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            c1_meta <= COUT1;
            c1s     <= c1_meta;
            c2_meta <= COUT2;
            c2s     <= c2_meta;
            DONE    <= 1'b0;

            case (state)
                IDLE: begin
                    RO_EN  <= 1'b0;
                    RO_RST <= 1'b1;
                    BUSY   <= 1'b0;
                    if (START) begin
                        idx         <= '0;
                        SEL         <= '0;
                        RESP        <= '0;
                        RESP_VALID  <= 1'b0;
                        TIE_ERR     <= 1'b0;
                        TIMEOUT_ERR <= 1'b0;
                        timer       <= '0;
                        BUSY        <= 1'b1;
                        state       <= CLEAR;
                    end
                end

                CLEAR: begin
                    if (timer == CLR_LAST) begin
                        timer  <= '0;
                        RO_RST <= 1'b0;
                        RO_EN  <= 1'b1;
                        state  <= RACE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                // A carry seen in the same cycle as the last timer tick still wins.
                RACE: begin
                    timer <= timer + 1'b1;
                    if (c1s || c2s || (timer == RACE_LAST)) begin
                        RO_EN    <= 1'b0;
                        race_bit <= c1s & ~c2s;
                        state    <= CAPTURE;
                        if (c1s && c2s) begin
                            TIE_ERR <= 1'b1;
                        end else if (!c1s && !c2s) begin
                            TIMEOUT_ERR <= 1'b1;
                        end
                    end
                end

                CAPTURE: begin
                    RESP[idx] <= race_bit;
                    if (idx == IDX_LAST) begin
                        DONE       <= 1'b1;
                        RESP_VALID <= 1'b1;
                        state      <= FINISH;
                    end else begin
                        idx    <= idx + 1'b1;
                        SEL    <= idx + 1'b1;
                        timer  <= '0;
                        RO_RST <= 1'b1;
                        state  <= CLEAR;
                    end
                end

                FINISH: begin
                    BUSY   <= 1'b0;
                    RO_RST <= 1'b1;
                    state  <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ropuf_challenge_sequencer.sv
// Self-checking bench: a behavioural PUF raises each carry a set number of
// enabled cycles after RO_EN, and a first-carry-wins model predicts the word.
module tb_ropuf_challenge_sequencer;

    localparam int SEL_W    = 2;
    localparam int NUM_CHAL = 4;
    localparam int CLR_CYC  = 4;
    localparam int TIMEOUT  = 64;
    localparam int TMR_W    = 11;

    logic                CLK = 1'b0;
    logic                RESET_N = 1'b1;
    logic                START = 1'b0;
    logic                COUT1 = 1'b0;
    logic                COUT2 = 1'b0;
    logic                BUSY;
    logic [SEL_W-1:0]    SEL;
    logic                RO_EN;
    logic                RO_RST;
    logic [NUM_CHAL-1:0] RESP;
    logic                RESP_VALID;
    logic                DONE;
    logic                TIE_ERR;
    logic                TIMEOUT_ERR;

    ropuf_challenge_sequencer #(
        .SEL_W(SEL_W), .NUM_CHAL(NUM_CHAL), .CLR_CYC(CLR_CYC),
        .TIMEOUT(TIMEOUT), .TMR_W(TMR_W)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .BUSY(BUSY), .SEL(SEL),
        .RO_EN(RO_EN), .RO_RST(RO_RST), .COUT1(COUT1), .COUT2(COUT2),
        .RESP(RESP), .RESP_VALID(RESP_VALID), .DONE(DONE),
        .TIE_ERR(TIE_ERR), .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Carry delay per challenge in enabled cycles; 0 means the carry never comes.
    int d1[NUM_CHAL];
    int d2[NUM_CHAL];

    logic [NUM_CHAL-1:0] exp_resp;
    logic                exp_tie;
    logic                exp_to;
    bit                  chal_to[NUM_CHAL];

    int  en_cnt = 0;
    int  en_len_q[$];
    int  rst_len_q[$];
    int  sel_q[$];
    int  en_run = 0;
    int  rst_run = 0;
    int  done_count = 0;
    bit  both_high = 0;
    bit  sel_glitch = 0;
    logic             prev_en = 1'b0;
    logic [SEL_W-1:0] prev_sel = '0;

    always @(negedge CLK) begin
        if (RO_RST) begin
            en_cnt = 0;
            COUT1  = 1'b0;
            COUT2  = 1'b0;
        end else if (RO_EN) begin
            en_cnt++;
            if (en_cnt == d1[SEL]) COUT1 = 1'b1;
            if (en_cnt == d2[SEL]) COUT2 = 1'b1;
        end
    end

    always @(negedge CLK) begin
        if (!RESET_N) begin
            en_run  = 0;
            rst_run = 0;
            prev_en = 1'b0;
        end else begin
            if (RO_EN && RO_RST) both_high = 1;
            if (BUSY && RO_RST) rst_run++;
            if (RO_EN && !prev_en) begin
                rst_len_q.push_back(rst_run);
                sel_q.push_back(int'(SEL));
                rst_run = 0;
            end
            if (RO_EN) begin
                if (prev_en && SEL != prev_sel) sel_glitch = 1;
                en_run++;
            end else if (prev_en) begin
                en_len_q.push_back(en_run);
                en_run = 0;
            end
            if (DONE) done_count++;
            prev_en  = RO_EN;
            prev_sel = SEL;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A carry only counts if it clears the synchronizer before the race gives up.
    function automatic int effective(input int d);
        return (d >= 1 && d <= TIMEOUT - 2) ? d : -1;
    endfunction

    task automatic predict();
        int a;
        int b;
        exp_resp = '0;
        exp_tie  = 1'b0;
        exp_to   = 1'b0;
        for (int i = 0; i < NUM_CHAL; i++) begin
            a = effective(d1[i]);
            b = effective(d2[i]);
            chal_to[i] = 0;
            if (a < 0 && b < 0) begin
                exp_to = 1'b1;
                chal_to[i] = 1;
            end else if (a == b) begin
                exp_tie = 1'b1;
            end else if (b < 0 || (a >= 0 && a < b)) begin
                exp_resp[i] = 1'b1;
            end
        end
    endtask

    task automatic apply_stimulus(input bit poke_start);
        bit got;
        predict();
        en_len_q.delete();
        rst_len_q.delete();
        sel_q.delete();
        done_count = 0;
        both_high  = 0;
        sel_glitch = 0;

        @(negedge CLK); START = 1'b1;
        @(negedge CLK); START = 1'b0;
        check_output("busy_after_start", BUSY, 1);
        check_output("valid_cleared", RESP_VALID, 0);
        check_output("tie_cleared", TIE_ERR, 0);
        check_output("timeout_cleared", TIMEOUT_ERR, 0);
        check_output("resp_cleared", RESP, 0);

        if (poke_start) begin
            got = 0;
            for (int n = 0; n < 200 && !got; n++) begin
                @(negedge CLK);
                if (RO_EN) got = 1;
            end
            check_output("race_reached", got, 1);
            START = 1'b1;
            @(negedge CLK); START = 1'b0;
        end

        got = 0;
        for (int n = 0; n < 4000 && !got; n++) begin
            @(negedge CLK);
            if (DONE) got = 1;
        end
        check_output("done_seen", got, 1);
        check_output("busy_on_done", BUSY, 1);
        check_output("valid_on_done", RESP_VALID, 1);
        check_output("resp", RESP, exp_resp);
        check_output("tie_err", TIE_ERR, exp_tie);
        check_output("timeout_err", TIMEOUT_ERR, exp_to);

        @(negedge CLK);
        check_output("done_pulse_ends", DONE, 0);
        check_output("busy_drops", BUSY, 0);
        check_output("valid_held", RESP_VALID, 1);
        repeat (3) @(negedge CLK);
        check_output("stays_idle", BUSY, 0);
        check_output("valid_still_held", RESP_VALID, 1);
        check_output("done_count", done_count, 1);
        check_output("en_rst_overlap", both_high, 0);
        check_output("sel_moved_in_race", sel_glitch, 0);
        check_output("race_count", en_len_q.size(), NUM_CHAL);
        check_output("clear_count", rst_len_q.size(), NUM_CHAL);
        for (int i = 0; i < NUM_CHAL && i < rst_len_q.size(); i++) begin
            check_output("clear_len", rst_len_q[i], CLR_CYC);
            check_output("sel_order", sel_q[i], i);
        end
        for (int i = 0; i < NUM_CHAL && i < en_len_q.size(); i++) begin
            if (chal_to[i]) check_output("timeout_en_len", en_len_q[i], TIMEOUT);
        end
    endtask

    initial begin
        bit hit;

        for (int i = 0; i < NUM_CHAL; i++) begin
            d1[i] = 0;
            d2[i] = 0;
        end

        #1 RESET_N = 1'b0;
        #2;
        check_output("rst_sel", SEL, 0);
        check_output("rst_ro_en", RO_EN, 0);
        check_output("rst_ro_rst", RO_RST, 1);
        check_output("rst_resp", RESP, 0);
        check_output("rst_valid", RESP_VALID, 0);
        check_output("rst_done", DONE, 0);
        check_output("rst_busy", BUSY, 0);
        check_output("rst_tie", TIE_ERR, 0);
        check_output("rst_timeout", TIMEOUT_ERR, 0);
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        repeat (2) @(negedge CLK);

        // COUT1 first on even challenges, COUT2 first on odd ones.
        d1 = '{20, 30, 20, 30};
        d2 = '{30, 20, 30, 20};
        apply_stimulus(0);

        d1 = '{20, 25, 20, 30};
        d2 = '{30, 25, 30, 20};
        apply_stimulus(0);

        d1 = '{20, 30, 20, 0};
        d2 = '{30, 20, 30, 0};
        apply_stimulus(0);

        d1 = '{12, 9, 33, 5};
        d2 = '{7, 15, 3, 6};
        apply_stimulus(1);

        d1 = '{20, 30, 20, 30};
        d2 = '{30, 20, 30, 20};
        @(negedge CLK); START = 1'b1;
        @(negedge CLK); START = 1'b0;
        hit = 0;
        for (int n = 0; n < 2000 && !hit; n++) begin
            @(negedge CLK);
            if (RO_EN && SEL == 2'd2) hit = 1;
        end
        check_output("reach_sel2", hit, 1);
        #2 RESET_N = 1'b0;
        #1;
        check_output("midrun_ro_en", RO_EN, 0);
        check_output("midrun_ro_rst", RO_RST, 1);
        check_output("midrun_busy", BUSY, 0);
        check_output("midrun_sel", SEL, 0);
        check_output("midrun_resp", RESP, 0);
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        repeat (3) @(negedge CLK);
        apply_stimulus(0);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NUM_CHAL; i++) begin
                d1[i] = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 40));
                d2[i] = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 40));
            end
            apply_stimulus($urandom_range(0, 1) == 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
